// File: rtl/stream_mux.sv
// stream_mux: N-channel, W-bit stream multiplexer with a one-entry registered
// output stage. A channel is picked either by the external sel bus (MODE=0) or
// by a round-robin arbiter (MODE=1) that starts searching after the last
// granted channel.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both 1. A producer holds its data stable while valid=1 and
// ready=0. out_valid/out_data/out_chan change only after a transfer out or a
// transfer in. in_ready is combinational. It is 1 for at most one channel, and
// only for a channel that is currently valid.
module stream_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic [SEL_W-1:0]             sel,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  output logic [SEL_W-1:0]             out_chan,
  input  logic                         out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [SEL_W-1:0] rr_cand;
  logic             rr_found;
  logic             fix_ok;
  logic [SEL_W-1:0] cand;
  logic             have_cand;
  logic             can_load;
  logic             load;

  // Round-robin search: the first valid channel after last_q, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!rr_found && in_valid[(int'(last_q) + k) % CHANNELS]) begin
        rr_found = 1'b1;
        rr_cand  = SEL_W'((int'(last_q) + k) % CHANNELS);
      end
    end
  end

  // Candidate choice. A select value beyond the channel count, or an idle
  // channel, gives no candidate, so an invalid input is never granted.
  always_comb begin
    fix_ok    = (int'(sel) < CHANNELS) && in_valid[sel];
    cand      = sel;
    have_cand = fix_ok;
    if (MODE == 1) begin
      cand      = rr_cand;
      have_cand = rr_found;
    end
  end

  // The output register can take a word when empty or while it drains.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    load     = !rst && can_load && have_cand;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load && (int'(cand) == i);
    end
  end

  // Next state of the output stage and the arbitration pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      out_data_d  = in_data[int'(cand)*WIDTH +: WIDTH];
      out_chan_d  = cand;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        last_d = cand;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a fixed-select 4-channel build (d0), a
// round-robin 4-channel build (d1) and a fixed-select 8-channel build (d8)
// share one clock and reset and are stepped together.
module tb_stream_mux;

  logic clk;
  logic rst;

  logic [15:0] d0_in_data;
  logic [3:0]  d0_in_valid, d0_in_ready;
  logic [1:0]  d0_sel, d0_out_chan;
  logic [3:0]  d0_out_data;
  logic        d0_out_valid, d0_out_ready;

  logic [15:0] d1_in_data;
  logic [3:0]  d1_in_valid, d1_in_ready;
  logic [1:0]  d1_sel, d1_out_chan;
  logic [3:0]  d1_out_data;
  logic        d1_out_valid, d1_out_ready;

  logic [31:0] d8_in_data;
  logic [7:0]  d8_in_valid, d8_in_ready;
  logic [2:0]  d8_sel, d8_out_chan;
  logic [3:0]  d8_out_data;
  logic        d8_out_valid, d8_out_ready;

  int checks = 0;
  int errors = 0;

  stream_mux #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_d0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_chan(d0_out_chan), .out_ready(d0_out_ready)
  );

  stream_mux #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_chan(d1_out_chan), .out_ready(d1_out_ready)
  );

  stream_mux #(.WIDTH(4), .CHANNELS(8), .MODE(0)) u_d8 (
    .clk(clk), .rst(rst), .in_data(d8_in_data), .in_valid(d8_in_valid),
    .in_ready(d8_in_ready), .sel(d8_sel), .out_data(d8_out_data),
    .out_valid(d8_out_valid), .out_chan(d8_out_chan), .out_ready(d8_out_ready)
  );

  // Clock and run-time bound
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ch;
    // 1. reset held with everything valid and downstream ready
    rst          = 1'b1;
    d0_in_data   = 16'h0A00;  // ch2 = A
    d0_in_valid  = 4'b1111;
    d0_sel       = 2'd2;
    d0_out_ready = 1'b1;
    d1_in_data   = 16'h4321;  // ch0..ch3 = 1,2,3,4
    d1_in_valid  = 4'b1111;
    d1_sel       = 2'd0;
    d1_out_ready = 1'b1;
    d8_in_data   = 32'h0000_0070;  // ch1 = 7
    d8_in_valid  = 8'h0F;
    d8_sel       = 3'd5;
    d8_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_d0_valid", d0_out_valid, 0);
    chk("rst_d0_ready", d0_in_ready, 0);
    chk("rst_d1_valid", d1_out_valid, 0);
    chk("rst_d1_ready", d1_in_ready, 0);
    chk("rst_d1_data",  d1_out_data, 0);
    chk("rst_d8_valid", d8_out_valid, 0);

    rst = 1'b0;
    #1;
    chk("rr_first_ready", d1_in_ready, 4'b0001);
    chk("fix_sel2_ready", d0_in_ready, 4'b0100);
    chk("sel5_idle_ready", d8_in_ready, 0);
    d8_sel = 3'd1;
    #1;
    chk("sel1_ready8", d8_in_ready, 8'h02);
    tick();
    chk("rr_first_chan",  d1_out_chan, 0);
    chk("rr_first_data",  d1_out_data, 4'h1);
    chk("rr_first_valid", d1_out_valid, 1);
    chk("fix_data",  d0_out_data, 4'hA);
    chk("fix_chan",  d0_out_chan, 2);
    chk("fix_valid", d0_out_valid, 1);
    chk("sel1_data8", d8_out_data, 4'h7);
    chk("sel1_chan8", d8_out_chan, 1);

    // 3. full rotation, one word per cycle
    for (int k = 1; k < 8; k++) begin
      chk("rot_ready", d1_in_ready, 32'(1 << (k % 4)));
      tick();
      chk("rot_chan",  d1_out_chan, k % 4);
      chk("rot_data",  d1_out_data, (k % 4) + 1);
      chk("rot_valid", d1_out_valid, 1);
    end

    // 4. only ch1 and ch3 valid: grants alternate
    d1_in_valid = 4'b1010;
    #1;
    for (int j = 0; j < 4; j++) begin
      ch = (j % 2 == 0) ? 1 : 3;
      chk("alt_ready", d1_in_ready, 32'(1 << ch));
      tick();
      chk("alt_chan", d1_out_chan, ch);
      chk("alt_data", d1_out_data, ch + 1);
    end

    // 5. backpressure; d0 also sees a sel change while its word is held
    d1_out_ready = 1'b0;
    d0_out_ready = 1'b0;
    d0_sel       = 2'd1;
    d0_in_data   = 16'h0A50;  // ch1 = 5
    #1;
    chk("stall_ready_d1", d1_in_ready, 0);
    chk("stall_ready_d0", d0_in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_data",  d1_out_data, 4'h4);
      chk("stall_chan",  d1_out_chan, 3);
      chk("stall_valid", d1_out_valid, 1);
      chk("stall_rdy",   d1_in_ready, 0);
      chk("hold_sel_chan", d0_out_chan, 2);
      chk("hold_sel_data", d0_out_data, 4'hA);
    end
    d1_out_ready = 1'b1;
    d0_out_ready = 1'b1;
    #1;
    chk("unstall_ready_d1", d1_in_ready, 4'b0010);
    chk("unstall_ready_d0", d0_in_ready, 4'b0010);
    tick();
    chk("swap_chan",  d1_out_chan, 1);
    chk("swap_data",  d1_out_data, 4'h2);
    chk("swap_valid", d1_out_valid, 1);
    chk("newsel_chan", d0_out_chan, 1);
    chk("newsel_data", d0_out_data, 4'h5);

    // drain with nothing to load: valid drops, data/chan hold
    d0_in_valid = 4'b0000;
    #1;
    chk("idle_ready_d0", d0_in_ready, 0);
    tick();
    chk("drain_valid", d0_out_valid, 0);
    chk("drain_data",  d0_out_data, 4'h5);
    chk("drain_chan",  d0_out_chan, 1);
    chk("alt2_chan",   d1_out_chan, 3);

    // 6. reset mid-rotation
    d1_in_valid = 4'b1111;
    #1;
    chk("mid_ready", d1_in_ready, 4'b0001);
    tick();
    chk("mid_chan",  d1_out_chan, 0);
    chk("mid_valid", d1_out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", d1_out_valid, 0);
    chk("async_data",  d1_out_data, 0);
    chk("async_ready", d1_in_ready, 0);
    d1_in_valid = 4'b1100;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", d1_in_ready, 4'b0100);
    tick();
    chk("post_rst_chan",  d1_out_chan, 2);
    chk("post_rst_data",  d1_out_data, 4'h3);
    chk("post_rst_valid", d1_out_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
